// File: rtl/simon_sequence_player_if.sv
// rtl/simon_sequence_player_if.sv - command and playback signals between controller and sequence player
interface simon_sequence_player_if #(
    parameter int MAX_LEN = 16
) ();
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic             start;
    logic             add_step;
    logic             clear;
    logic [3:0]       button;
    logic             button_en;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] seq_len;
    logic             full;

    modport master (
        output start, add_step, clear,
        input  button, button_en, busy, done, seq_len, full
    );

    modport slave (
        input  start, add_step, clear,
        output button, button_en, busy, done, seq_len, full
    );
endinterface

// File: rtl/simon_sequence_player.sv
// rtl/simon_sequence_player.sv - stores the Simon colour sequence and plays it back as timed button codes
module simon_sequence_player #(
    parameter int MAX_LEN    = 16,
    parameter int ON_CYCLES  = 12_500_000,
    parameter int OFF_CYCLES = 6_250_000
) (
    input  logic                  clk,
    input  logic                  rst,
    simon_sequence_player_if.slave ctrl
);
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMAX    = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [LEN_W-1:0]   seq_len_q, seq_len_d;
    logic [7:0]         lfsr_q;
    logic [1:0]         colour_q [MAX_LEN];
    logic [3:0]         button_q, button_d;
    logic               button_en_q, button_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wr_en;
    logic               full;
    logic               last_step;
    logic [1:0]         first_colour;

    assign full      = (seq_len_q == LEN_W'(MAX_LEN));
    assign idx_nxt   = idx_q + IDX_W'(1);
    assign last_step = ((LEN_W'(idx_q) + LEN_W'(1)) == seq_len_q);
    // A start that coincides with the very first add_step must see the colour being written.
    assign first_colour = (wr_en && seq_len_q == '0) ? lfsr_q[1:0] : colour_q[0];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        seq_len_d   = seq_len_q;
        wr_en       = 1'b0;
        button_d    = 4'd0;
        button_en_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl.clear) begin
                    seq_len_d = '0;
                end else begin
                    if (ctrl.add_step && !full) begin
                        wr_en     = 1'b1;
                        seq_len_d = seq_len_q + LEN_W'(1);
                    end
                    if (ctrl.start && seq_len_d != '0) begin
                        state_d     = ON;
                        idx_d       = '0;
                        timer_d     = '0;
                        button_d    = {2'b00, first_colour} + 4'd1;
                        button_en_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
            end
            ON: begin
                busy_d = 1'b1;
                if (timer_q == TIMER_W'(ON_CYCLES - 1)) begin
                    state_d = OFF;
                    timer_d = '0;
                end else begin
                    timer_d     = timer_q + TIMER_W'(1);
                    button_d    = {2'b00, colour_q[idx_q]} + 4'd1;
                    button_en_d = 1'b1;
                end
            end
            OFF: begin
                if (timer_q == TIMER_W'(OFF_CYCLES - 1)) begin
                    timer_d = '0;
                    if (last_step) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ON;
                        idx_d       = idx_nxt;
                        button_d    = {2'b00, colour_q[idx_nxt]} + 4'd1;
                        button_en_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            timer_q     <= '0;
            seq_len_q   <= '0;
            lfsr_q      <= 8'hA5;
            button_q    <= 4'd0;
            button_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            seq_len_q   <= seq_len_d;
            lfsr_q      <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            button_q    <= button_d;
            button_en_q <= button_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) colour_q[i] <= 2'd0;
        end else if (wr_en) begin
            colour_q[seq_len_q[IDX_W-1:0]] <= lfsr_q[1:0];
        end
    end

    assign ctrl.button    = button_q;
    assign ctrl.button_en = button_en_q;
    assign ctrl.busy      = busy_q;
    assign ctrl.done      = done_q;
    assign ctrl.seq_len   = seq_len_q;
    assign ctrl.full      = full;
endmodule

// File: doc/simon_sequence_player.md
# simon_sequence_player

Upstream stage of the Simon LED decoder: it holds the game's colour sequence and plays it back as timed button codes. Each new step comes from an on-chip LFSR. During playback it drives `button` (codes 1–4) and `button_en` into the LED-select stage, with a timed on/off cadence per step. The game controller sequences it with single-cycle command pulses.

## Interface
Parameters:
- `MAX_LEN`, 16: maximum sequence length in steps. `seq_len` width is $clog2(MAX_LEN+1).
- `ON_CYCLES`, 12_500_000: clocks each step is lit (`button_en`=1).
- `OFF_CYCLES`, 6_250_000: clocks of dark gap after each step.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse: play the stored sequence.
- `add_step`  in  1  one-cycle pulse: append one random step.
- `clear`  in  1  one-cycle pulse: set the sequence length to 0.
- `button`  out  4  code to the LED decoder: step colour + 1 (1..4) while lit, else 0.
- `button_en`  out  1  high while a step is lit.
- `busy`  out  1  high in the ON and OFF states.
- `done`  out  1  one-cycle pulse when playback ends.
- `seq_len`  out  5  number of stored steps (0..MAX_LEN).
- `full`  out  1  high when `seq_len == MAX_LEN`.

## Operation
- Storage: MAX_LEN × 2-bit colour registers. `seq_len` counter. 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset.
- LFSR advance:
  - The LFSR advances every clock regardless of state.
  - `add_step` stores `lfsr[1:0]` at index `seq_len`, then increments `seq_len`.
- FSM states IDLE, ON, OFF. Reset enters IDLE.
- IDLE:
  - On `start` with the effective length > 0: set idx=0, clear the timer, go to ON.
  - Effective length is `seq_len` after any same-cycle `add_step`.
  - `start` with effective length 0 is ignored. No `done` pulse.
- ON:
  - `button` = colour[idx]+1, `button_en`=1.
  - Stay exactly ON_CYCLES clocks, then go to OFF.
- OFF:
  - `button`=0, `button_en`=0.
  - Stay exactly OFF_CYCLES clocks.
  - Then, if idx == `seq_len`-1: go to IDLE and pulse `done`.
  - Otherwise: idx+1, go to ON.
- Command rules in IDLE:
  - `clear` beats `add_step` in the same cycle.
  - `add_step` when `full` is ignored.
  - `start` together with `clear`: clear applies and start is ignored.
- `add_step`, `clear` and `start` are ignored while `busy`.
- Stored colours persist across playbacks. Only `clear` or `rst` discards them; `clear` does not zero the registers.
- Timer width covers max(ON_CYCLES, OFF_CYCLES).

## Timing
- Reset values:
  - `button`=0, `button_en`=0, `busy`=0, `done`=0, `seq_len`=0, `full`=0.
  - idx=0, timer=0, LFSR=8'hA5.
- All outputs are registered. `full` may be decoded combinationally from the registered `seq_len`.
- Start latency: `start` sampled at edge k. `button_en`, `busy` and the valid `button` are high from k+1.
- Per step: ON_CYCLES clocks lit, then OFF_CYCLES clocks dark. `button` and `button_en` change on the same edge.
- Total busy time = N·(ON_CYCLES+OFF_CYCLES) clocks for N steps.
- `done` is high for exactly one cycle, the first IDLE cycle, coincident with `busy` falling.
- A new `start` is accepted in that same cycle.
- `seq_len` updates on the edge after `add_step` or `clear`.
- `rst` asserted mid-playback: all outputs are zero immediately (asynchronously) and the sequence is lost.

## Test plan
Bench parameters: ON_CYCLES=4, OFF_CYCLES=2, MAX_LEN=16.
- Reset, then three `add_step` pulses and `start` → `seq_len`=3. `button_en` is high for cycles 1–4, 7–10 and 13–16 after start, low elsewhere. `done` pulses at cycle 19. `button` ∈ 1..4 whenever lit, 0 otherwise.
- `start` twice on the same stored sequence → identical `button` code sequences. `seq_len` stays 3.
- 17 `add_step` pulses → `seq_len`=16 and `full`=1 after the 16th; the 17th is ignored. `start` → 16 lit steps, 96 busy cycles.
- `add_step`/`clear` during playback → ignored: `seq_len` unchanged, and the remaining codes match the earlier run. `clear`+`add_step` together in IDLE → `seq_len`=0.
- `start` with `seq_len`=0 → `busy` stays 0 and no `done`. `start`+`add_step` together from empty → one lit step, then `done`.
- `rst` pulsed during ON → `button`=0, `button_en`=0, `busy`=0 before the next clock edge; `seq_len`=0 afterward; a subsequent `start` is ignored.
